// File: rtl/ppe_weight_rx.sv
// Receive endpoint for filter-weight packets: reassembles a 3+2 weight burst
// addressed to PE_ID into one 5-weight row and hands it off over valid/ready.
module ppe_weight_rx #(
  parameter logic [3:0] PE_ID            = 4'd5,
  parameter int         WEIGHT_WIDTH     = 8,
  parameter logic [3:0] OP_WEIGHT        = 4'd0,
  parameter logic [3:0] OP_TIMESTEP_DONE = 4'd15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [32:0]               in_packet,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [5*WEIGHT_WIDTH-1:0] row_data,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      ts_done,
  output logic [2:0]                row_count,
  output logic                      err
);

  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    WAIT_HI = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3*WEIGHT_WIDTH-1:0] lo_q, lo_d;
  logic [5*WEIGHT_WIDTH-1:0] row_q, row_d;
  logic                      tsDone_q, tsDone_d;
  logic                      err_q, err_d;
  logic [2:0]                count_q, count_d;

  logic [3:0]  pktDest;
  logic [3:0]  pktOp;
  logic [24:0] pktData;
  logic        pktFire;
  logic        pktOwn;
  logic        unusedDataBits;

  assign pktDest = in_packet[32:29];
  assign pktOp   = in_packet[28:25];
  assign pktData = in_packet[24:0];
  assign unusedDataBits = ^pktData[24:3*WEIGHT_WIDTH];

  // Backpressure is a pure decode of the state register, held low during reset.
  assign in_ready = !reset && (state_q != FULL);
  assign pktFire  = in_valid && in_ready;
  assign pktOwn   = (pktDest == PE_ID);

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    row_d    = row_q;
    tsDone_d = 1'b0;
    err_d    = err_q;
    count_d  = count_q;
    case (state_q)
      WAIT_LO: begin
        if (pktFire && pktOwn) begin
          if (pktOp == OP_WEIGHT) begin
            lo_d    = pktData[3*WEIGHT_WIDTH-1:0];
            state_d = WAIT_HI;
          end else if (pktOp == OP_TIMESTEP_DONE) begin
            tsDone_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_HI: begin
        if (pktFire && pktOwn) begin
          if (pktOp == OP_WEIGHT) begin
            // row_data only changes here, so it stays stable until the next full row
            row_d   = {pktData[2*WEIGHT_WIDTH-1:0], lo_q};
            state_d = FULL;
          end else if (pktOp == OP_TIMESTEP_DONE) begin
            tsDone_d = 1'b1;
            lo_d     = '0;
            state_d  = WAIT_LO;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (row_ready) begin
          state_d = WAIT_LO;
          if (count_q != 3'd7) begin
            count_d = count_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = WAIT_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_LO;
      lo_q     <= '0;
      row_q    <= '0;
      tsDone_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      row_q    <= row_d;
      tsDone_q <= tsDone_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign row_data  = row_q;
  assign row_valid = (state_q == FULL);
  assign ts_done   = tsDone_q;
  assign row_count = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ppe_weight_rx.sv
// Directed self-checking bench for ppe_weight_rx: row assembly, backpressure,
// address filtering, timestep abort, error/saturation and mid-burst reset.
module tb_ppe_weight_rx;

  logic        clk;
  logic        reset;
  logic [32:0] in_packet;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic        ts_done;
  logic [2:0]  row_count;
  logic        err;

  int testCount;
  int failCount;

  ppe_weight_rx dut (
    .clk       (clk),
    .reset     (reset),
    .in_packet (in_packet),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_data  (row_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .ts_done   (ts_done),
    .row_count (row_count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] mkPkt(input logic [3:0] dest, input logic [3:0] op,
                                        input logic [24:0] data);
    return {dest, op, data};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one packet and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [32:0] pkt);
    int waitCycles;
    @(negedge clk);
    in_packet  = pkt;
    in_valid   = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_packet = '0;
    row_ready = 1'b1;

    // Reset values
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_row_valid", 64'(row_valid), 64'd0);
    checkOutput("rst_row_data", 64'(row_data), 64'd0);
    checkOutput("rst_ts_done", 64'(ts_done), 64'd0);
    checkOutput("rst_row_count", 64'(row_count), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Nominal row
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h030201));
    checkOutput("nom_half_valid", 64'(row_valid), 64'd0);
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h000504));
    checkOutput("nom_row_valid", 64'(row_valid), 64'd1);
    checkOutput("nom_row_data", 64'(row_data), 64'h0504030201);
    checkOutput("nom_in_ready_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("nom_row_valid_drop", 64'(row_valid), 64'd0);
    checkOutput("nom_row_count", 64'(row_count), 64'd1);
    checkOutput("nom_in_ready_back", 64'(in_ready), 64'd1);

    // Backpressure
    row_ready = 1'b0;
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h131211));
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h001514));
    checkOutput("bp_row_data", 64'(row_data), 64'h1514131211);
    @(negedge clk);
    in_packet = mkPkt(4'd5, 4'd0, 25'h232221);
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_row_valid_hold", 64'(row_valid), 64'd1);
    checkOutput("bp_row_data_hold", 64'(row_data), 64'h1514131211);
    row_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_release_row_valid", 64'(row_valid), 64'd0);
    checkOutput("bp_release_count", 64'(row_count), 64'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_third_taken_valid", 64'(row_valid), 64'd0);
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h002524));
    checkOutput("bp_third_row_data", 64'(row_data), 64'h2524232221);
    @(posedge clk);
    #1;
    checkOutput("bp_count3", 64'(row_count), 64'd3);

    // Address filter
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h333231));
    applyStimulus(mkPkt(4'd6, 4'd0, 25'hFFFFFF));
    checkOutput("af_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(mkPkt(4'd6, 4'd15, 25'h0));
    checkOutput("af_no_ts_done", 64'(ts_done), 64'd0);
    applyStimulus(mkPkt(4'd6, 4'd3, 25'h0));
    checkOutput("af_no_err", 64'(err), 64'd0);
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h003534));
    checkOutput("af_row_valid", 64'(row_valid), 64'd1);
    checkOutput("af_row_data", 64'(row_data), 64'h3534333231);
    @(posedge clk);
    #1;
    checkOutput("af_count4", 64'(row_count), 64'd4);

    // Timestep abort
    applyReset();
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h030201));
    applyStimulus(mkPkt(4'd5, 4'd15, 25'h0));
    checkOutput("ts_pulse", 64'(ts_done), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("ts_pulse_end", 64'(ts_done), 64'd0);
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h0B0A09));
    checkOutput("ts_half_valid", 64'(row_valid), 64'd0);
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h000D0C));
    checkOutput("ts_row_data", 64'(row_data), 64'h0D0C0B0A09);
    @(posedge clk);
    #1;
    checkOutput("ts_row_count", 64'(row_count), 64'd1);

    // Error and saturation
    applyStimulus(mkPkt(4'd5, 4'd3, 25'h0));
    checkOutput("err_set", 64'(err), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      logic [23:0] loW;
      logic [15:0] hiW;
      loW = 24'(i) * 24'h010101;
      hiW = 16'(i + 16) * 16'h0101;
      applyStimulus(mkPkt(4'd5, 4'd0, {1'b0, loW}));
      applyStimulus(mkPkt(4'd5, 4'd0, {9'd0, hiW}));
      checkOutput($sformatf("sat_row%0d", i), 64'(row_data), {24'd0, hiW, loW});
    end
    @(posedge clk);
    #1;
    checkOutput("sat_count", 64'(row_count), 64'd7);
    checkOutput("err_sticky", 64'(err), 64'd1);

    // Reset mid-burst
    applyStimulus(mkPkt(4'd5, 4'd0, 25'hAAAAAA));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid_rst_row_valid", 64'(row_valid), 64'd0);
    checkOutput("mid_rst_row_data", 64'(row_data), 64'd0);
    checkOutput("mid_rst_count", 64'(row_count), 64'd0);
    checkOutput("mid_rst_err", 64'(err), 64'd0);
    checkOutput("mid_rst_ts_done", 64'(ts_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h434241));
    checkOutput("mid_rst_half_valid", 64'(row_valid), 64'd0);
    applyStimulus(mkPkt(4'd5, 4'd0, 25'h004544));
    checkOutput("mid_rst_row_data_new", 64'(row_data), 64'h4544434241);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_row_count_new", 64'(row_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
